// File: rtl/tf_table_pkg.sv
// tf_table_pkg: shared constants, types and FSM states for the twiddle-factor table.
package tf_table_pkg;
  localparam int DATA_WIDTH = 23;
  localparam int STAGE_CNT  = 8;
  localparam int NUM_PORTS  = 2;
  localparam int Q          = 8380417;
  localparam int TF_DEPTH   = 1 << STAGE_CNT;
  typedef logic [DATA_WIDTH-1:0] tf_data_t;
  typedef enum logic [1:0] {EMPTY, LOADING, READY} tf_state_e;
endpackage

// File: rtl/tf_table_if.sv
// tf_table_if: load stream and multi-port lookup bus of the twiddle-factor table.
interface tf_table_if #(
  parameter int DATA_WIDTH = 23,
  parameter int STAGE_CNT  = 8,
  parameter int NUM_PORTS  = 2
);
  localparam int SW = $clog2(STAGE_CNT);
  logic                                 load_start;
  logic                                 load_valid;
  logic [DATA_WIDTH-1:0]                load_data;
  logic                                 load_ready;
  logic                                 table_ready;
  logic                                 mode_inv;
  logic [NUM_PORTS-1:0]                 rd_valid;
  logic [NUM_PORTS-1:0][SW-1:0]         rd_stage;
  logic [NUM_PORTS-1:0][STAGE_CNT-2:0]  rd_addr;
  logic [NUM_PORTS-1:0]                 out_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data;
  modport master (
    output load_start, load_valid, load_data, mode_inv, rd_valid, rd_stage, rd_addr,
    input  load_ready, table_ready, out_valid, out_data
  );
  modport slave (
    input  load_start, load_valid, load_data, mode_inv, rd_valid, rd_stage, rd_addr,
    output load_ready, table_ready, out_valid, out_data
  );
endinterface

// File: rtl/tf_table_rd_lane.sv
// tf_rd_lane: one read port - index calculation, read register and inverse negation.
module tf_rd_lane #(
  parameter int DATA_WIDTH = 23,
  parameter int STAGE_CNT  = 8,
  parameter int Q          = 8380417,
  localparam int SW        = $clog2(STAGE_CNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic                  inv,
  input  logic [SW-1:0]         stage,
  input  logic [STAGE_CNT-2:0]  addr,
  output logic [STAGE_CNT-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic [STAGE_CNT-1:0]  base, mask, a;
  logic                  v1, inv1;
  logic [DATA_WIDTH-1:0] d1;
  // Mirroring within a stage is a bitwise complement of the offset under the stage mask.
  always_comb begin
    base = STAGE_CNT'(1) << stage;
    mask = base - STAGE_CNT'(1);
    a    = {1'b0, addr};
    idx  = base | ((inv ? ~a : a) & mask);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      inv1      <= 1'b0;
      d1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      v1        <= accept;
      inv1      <= inv;
      d1        <= accept ? word : '0;
      out_valid <= v1;
      out_data  <= (inv1 && d1 != '0) ? DATA_WIDTH'(Q) - d1 : d1;
    end
  end
endmodule

// File: rtl/tf_table.sv
// tf_table: runtime-loaded twiddle table with NUM_PORTS 2-cycle lookup ports.
module tf_table
  import tf_table_pkg::*;
#(
  parameter int DATA_WIDTH = tf_table_pkg::DATA_WIDTH,
  parameter int STAGE_CNT  = tf_table_pkg::STAGE_CNT,
  parameter int NUM_PORTS  = tf_table_pkg::NUM_PORTS,
  parameter int Q          = tf_table_pkg::Q
) (
  input logic       clk,
  input logic       rst_n,
  tf_table_if.slave bus
);
  localparam int DEPTH = 1 << STAGE_CNT;
  localparam logic [STAGE_CNT-1:0] LAST = STAGE_CNT'(DEPTH - 1);
  tf_state_e                           state, state_n;
  logic [STAGE_CNT-1:0]                cnt, cnt_n;
  logic                                beat;
  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  logic [NUM_PORTS-1:0][STAGE_CNT-1:0] idx;
  assign beat            = bus.load_valid && state == LOADING;
  assign bus.load_ready  = state == LOADING;
  assign bus.table_ready = state == READY;
  // load_start outranks a coincident final beat; that beat is still written.
  always_comb begin
    cnt_n   = bus.load_start ? STAGE_CNT'(1) : beat ? cnt + STAGE_CNT'(1) : cnt;
    state_n = bus.load_start ? LOADING : (beat && cnt == LAST) ? READY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt   <= STAGE_CNT'(1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (beat) mem[cnt] <= bus.load_data;
  end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    tf_rd_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .STAGE_CNT (STAGE_CNT),
      .Q         (Q)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (bus.rd_valid[p] && state == READY),
      .inv      (bus.mode_inv),
      .stage    (bus.rd_stage[p]),
      .addr     (bus.rd_addr[p]),
      .idx      (idx[p]),
      .word     (mem[idx[p]]),
      .out_valid(bus.out_valid[p]),
      .out_data (bus.out_data[p])
    );
  end
endmodule

// File: tb/tb_tf_table.sv
// tb_tf_table: directed checks of load FSM, forward/inverse lookups, reload and reset.
module tb_tf_table;
  import tf_table_pkg::*;
  localparam int DW = tf_table_pkg::DATA_WIDTH;
  localparam int SC = tf_table_pkg::STAGE_CNT;
  localparam int NP = tf_table_pkg::NUM_PORTS;
  localparam int QM = tf_table_pkg::Q;
  logic clk, rst_n;
  int   n_chk, n_fail, cyc;
  tf_table_if #(.DATA_WIDTH(DW), .STAGE_CNT(SC), .NUM_PORTS(NP)) bus ();
  tf_table #(.DATA_WIDTH(DW), .STAGE_CNT(SC), .NUM_PORTS(NP), .Q(QM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++)
        assert (!(bus.rd_valid[p] && int'(bus.rd_stage[p]) >= SC))
          else $error("illegal rd_stage on port %0d", p);
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic inv, input logic v0, input int s0, input int a0,
                     input logic v1, input int s1, input int a1);
    bus.mode_inv    = inv;
    bus.rd_valid    = {v1, v0};
    bus.rd_stage[0] = 3'(s0);
    bus.rd_addr[0]  = 7'(a0);
    bus.rd_stage[1] = 3'(s1);
    bus.rd_addr[1]  = 7'(a1);
  endtask
  task automatic lookup(input logic inv, input logic v0, input int s0, input int a0,
                        input logic v1, input int s1, input int a1);
    req(inv, v0, s0, a0, v1, s1, a1);
    step();
    bus.rd_valid = '0;
    step();
  endtask
  task automatic load(input int mode, output int lr_cycles);
    lr_cycles      = 0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int i = 1; i < 256; i++) begin
      bus.load_data = mode == 1 ? (i == 12 ? '0 : DW'(i)) : mode == 2 ? DW'(3 * i) : DW'(i);
      if (bus.load_ready) lr_cycles++;
      step();
    end
    bus.load_valid = 1'b0;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    req(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    step();
    step();
    check("rst_load_ready", 64'(bus.load_ready), 0);
    check("rst_table_ready", 64'(bus.table_ready), 0);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_out_data", 64'(bus.out_data), 0);
    rst_n = 1'b1;
    step();
    lookup(1'b0, 1'b1, 3, 5, 1'b1, 7, 100);
    check("pre_load_valid", 64'(bus.out_valid), 0);
    check("pre_load_data", 64'(bus.out_data), 0);
    load(0, cyc);
    check("load_cycles", 64'(cyc), 255);
    check("ready_after_load", 64'(bus.table_ready), 1);
    check("load_ready_drop", 64'(bus.load_ready), 0);
    lookup(1'b0, 1'b1, 3, 5, 1'b1, 7, 100);
    check("fwd_valid", 64'(bus.out_valid), 2'b11);
    check("fwd_s3a5", 64'(bus.out_data[0]), 13);
    check("fwd_s7a100", 64'(bus.out_data[1]), 228);
    lookup(1'b1, 1'b1, 3, 5, 1'b1, 0, 77);
    check("inv_s3a5", 64'(bus.out_data[0]), 8380407);
    check("inv_s0", 64'(bus.out_data[1]), 8380416);
    lookup(1'b0, 1'b1, 0, 99, 1'b1, 0, 3);
    check("same_idx_p0", 64'(bus.out_data[0]), 1);
    check("same_idx_p1", 64'(bus.out_data[1]), 1);
    lookup(1'b1, 1'b1, 7, 127, 1'b0, 0, 0);
    check("inv_s7a127", 64'(bus.out_data[0]), 8380289);
    check("idle_port_valid", 64'(bus.out_valid), 2'b01);
    lookup(1'b0, 1'b1, 7, 127, 1'b1, 1, 1);
    check("fwd_s7a127", 64'(bus.out_data[0]), 255);
    check("fwd_s1a1", 64'(bus.out_data[1]), 3);
    req(1'b0, 1'b1, 2, 1, 1'b0, 0, 0);
    step();
    bus.rd_valid = '0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    check("inflight_valid", 64'(bus.out_valid), 2'b01);
    check("inflight_data", 64'(bus.out_data[0]), 5);
    check("restart_load_ready", 64'(bus.load_ready), 1);
    lookup(1'b0, 1'b1, 3, 5, 1'b1, 3, 5);
    check("reload_rd_valid", 64'(bus.out_valid), 0);
    check("reload_rd_data", 64'(bus.out_data), 0);
    load(1, cyc);
    check("reload_cycles", 64'(cyc), 255);
    lookup(1'b1, 1'b1, 3, 3, 1'b1, 3, 4);
    check("inv_zero", 64'(bus.out_data[0]), 0);
    check("inv_s3a4", 64'(bus.out_data[1]), 8380406);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      bus.load_data = DW'(i);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_table_ready", 64'(bus.table_ready), 0);
    check("midrst_load_ready", 64'(bus.load_ready), 0);
    check("midrst_out_valid", 64'(bus.out_valid), 0);
    bus.load_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    load(2, cyc);
    check("post_rst_ready", 64'(bus.table_ready), 1);
    lookup(1'b0, 1'b1, 3, 5, 1'b1, 7, 0);
    check("new_fwd_s3a5", 64'(bus.out_data[0]), 39);
    check("new_fwd_s7a0", 64'(bus.out_data[1]), 384);
    lookup(1'b1, 1'b1, 5, 0, 1'b1, 0, 0);
    check("new_inv_s5a0", 64'(bus.out_data[0]), 8380228);
    check("new_inv_s0", 64'(bus.out_data[1]), 8380414);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
